// File: rtl/lut_neuron_scanner.sv
// lut_neuron_scanner: sweeps every input code of one LUT neuron and streams its truth table as packed words
module lut_neuron_scanner #(
  parameter int IN_BITS = 8,
  parameter int WORD_W  = 32,
  parameter int SETTLE  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [IN_BITS-1:0] lut_in,
  input  logic               lut_out,
  output logic [WORD_W-1:0]  m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_last
);
  localparam int NWORDS = (1 << IN_BITS) / WORD_W;
  localparam int BW = $clog2(WORD_W);
  localparam int CW = $clog2(SETTLE + 1);
  typedef enum logic [1:0] {IDLE, DRIVE, EMIT, DONE} state_t;
  state_t state, state_n;
  logic [IN_BITS-1:0] addr;
  logic [IN_BITS-1:0] widx;
  logic [CW-1:0] cnt;
  logic sample, full, last_w;
  assign sample = state == DRIVE && cnt == CW'(SETTLE - 1);
  assign full = sample && addr[BW-1:0] == {BW{1'b1}};
  assign last_w = widx == IN_BITS'(NWORDS - 1);
  assign lut_in = addr;
  // next state: sweep codes, hold each finished word until accepted, pulse done after the last one
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = start ? DRIVE : IDLE;
      DRIVE:   state_n = full ? EMIT : DRIVE;
      EMIT:    state_n = m_ready ? (last_w ? DONE : DRIVE) : EMIT;
      default: state_n = IDLE;
    endcase
  end
  // state, counters, word assembly and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr    <= '0;
      widx    <= '0;
      cnt     <= '0;
      m_data  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end else begin
      state   <= state_n;
      busy    <= state_n == DRIVE || state_n == EMIT;
      done    <= state_n == DONE;
      m_valid <= state_n == EMIT;
      m_last  <= state_n == EMIT && last_w;
      if (state == IDLE && start) begin
        addr   <= '0;
        widx   <= '0;
        cnt    <= '0;
        m_data <= '0;
      end
      if (sample) begin
        m_data[addr[BW-1:0]] <= lut_out;
        addr <= addr + 1'b1;
        cnt  <= '0;
      end else if (state == DRIVE) begin
        cnt <= cnt + 1'b1;
      end
      if (state == EMIT && m_ready && !last_w) begin
        widx <= widx + 1'b1;
        cnt  <= '0;
      end
    end
  end
endmodule

// File: tb/tb_lut_neuron_scanner.sv
// tb_lut_neuron_scanner: randomized scoreboard bench for the LUT neuron table scanner
module tb_lut_neuron_scanner;
  logic clk = 0, rst_n = 0, start = 0, start3 = 0, m_ready = 1;
  logic busy, done, m_valid, m_last, lut_out;
  logic [7:0] lut_in;
  logic [31:0] m_data;
  logic busy3, done3, m_valid3, m_last3, lut_out3;
  logic [7:0] lut_in3;
  logic [31:0] m_data3;
  logic d1 = 0, d2 = 0;
  int cyc = 0;
  int errors = 0, checks = 0;
  int nmode = 0;
  logic tbl [256];
  logic [31:0] qd[$], qd3[$];
  logic ql[$], ql3[$];
  int qa[$], qa3[$];

  lut_neuron_scanner dut (.clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .lut_in(lut_in), .lut_out(lut_out), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last));
  lut_neuron_scanner #(.SETTLE(3)) dut3 (.clk(clk), .rst_n(rst_n), .start(start3), .busy(busy3), .done(done3),
    .lut_in(lut_in3), .lut_out(lut_out3), .m_data(m_data3), .m_valid(m_valid3), .m_ready(m_ready), .m_last(m_last3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // neuron models: 0 = lsb, 1 = const 1, 2 = const 0, 3 = code 200 detector, 4 = random table
  function automatic logic f(input int m, input logic [7:0] a);
    return m == 0 ? a[0] : m == 1 ? 1'b1 : m == 2 ? 1'b0 : m == 3 ? (a == 8'd200) : tbl[a];
  endfunction
  assign lut_out = f(nmode, lut_in);
  // slow neuron: lsb of the code, two cycles late
  always @(posedge clk) begin
    d1 <= lut_in3[0];
    d2 <= d1;
  end
  assign lut_out3 = d2;

  task automatic chk(input logic ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // monitors: pop the expected word on every handshake
  always @(negedge clk) begin : mon
    logic [31:0] d;
    logic l;
    int a;
    if (m_valid && m_ready) begin
      if (qd.size() == 0) chk(1'b0, "unexpected_word", m_data, 32'h0);
      else begin
        d = qd.pop_front(); l = ql.pop_front(); a = qa.pop_front();
        chk(m_data == d, "word", m_data, d);
        chk(m_last == l, "last", 32'(m_last), 32'(l));
        chk(cyc == a, "word_cycle", cyc, a);
      end
    end
  end
  always @(negedge clk) begin : mon3
    logic [31:0] d;
    logic l;
    int a;
    if (m_valid3 && m_ready) begin
      if (qd3.size() == 0) chk(1'b0, "unexpected_word3", m_data3, 32'h0);
      else begin
        d = qd3.pop_front(); l = ql3.pop_front(); a = qa3.pop_front();
        chk(m_data3 == d, "word3", m_data3, d);
        chk(m_last3 == l, "last3", 32'(m_last3), 32'(l));
        chk(cyc == a, "word3_cycle", cyc, a);
      end
    end
  end

  task automatic scan(input int mode, input int bp, input logic mid, input int rst_at);
    int t, c;
    logic [31:0] w;
    @(posedge clk); #1;
    t = cyc;
    nmode = mode;
    if (mode == 4) foreach (tbl[i]) tbl[i] = 1'($urandom_range(0, 1));
    start = 1;
    for (int k = 0; k < 8; k++) begin
      w = 0;
      for (int i = 0; i < 32; i++) w[i] = f(mode, 8'(k * 32 + i));
      qd.push_back(w);
      ql.push_back(k == 7);
      qa.push_back(t + 33 * (k + 1) + ((bp > 0 && k >= 3) ? bp : 0));
    end
    @(posedge clk); #1;
    start = 0;
    c = 1;
    chk(busy && lut_in == 0, "start_busy", 32'({busy, lut_in}), 32'h100);
    while (!done && c < 600) begin
      @(posedge clk); #1;
      c = cyc - t;
      if (mid) start = (c == 50);
      if (bp > 0) begin
        if (c == 132) m_ready = 0;
        if (c == 132 + bp) m_ready = 1;
        if (c >= 132 && c < 132 + bp)
          chk(m_valid && m_data == qd[0] && !m_last && lut_in == 8'd128, "bp_hold", m_data, qd[0]);
      end
      if (rst_at > 0 && c == rst_at) begin
        rst_n = 0;
        #1;
        chk({busy, done, m_valid, m_last, lut_in, m_data} == '0, "reset_mid",
            32'({busy, done, m_valid, m_last, lut_in}) | m_data, 32'h0);
        qd.delete(); ql.delete(); qa.delete();
        @(posedge clk); #1;
        rst_n = 1;
        return;
      end
    end
    chk(c == 265 + bp, "done_cycle", c, 265 + bp);
    chk(!busy && !m_valid, "done_idle", 32'({busy, m_valid}), 32'h0);
    chk(qd.size() == 0, "words_outstanding", qd.size(), 0);
  endtask

  task automatic scan3();
    int t, c;
    logic [31:0] w;
    @(posedge clk); #1;
    t = cyc;
    start3 = 1;
    for (int k = 0; k < 8; k++) begin
      w = 0;
      for (int i = 0; i < 32; i++) w[i] = f(0, 8'(k * 32 + i));
      qd3.push_back(w);
      ql3.push_back(k == 7);
      qa3.push_back(t + 97 * (k + 1));
    end
    @(posedge clk); #1;
    start3 = 0;
    c = 1;
    while (!done3 && c < 1000) begin
      @(posedge clk); #1;
      c = cyc - t;
    end
    chk(c == 777, "done3_cycle", c, 777);
    chk(qd3.size() == 0, "words3_outstanding", qd3.size(), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk({busy, done, m_valid, m_last, lut_in, m_data} == '0, "reset_state",
        32'({busy, done, m_valid, m_last, lut_in}) | m_data, 32'h0);
    rst_n = 1;
    scan(0, 0, 0, 0);
    scan(1, 0, 0, 0);
    scan(2, 0, 0, 0);
    scan(3, 0, 0, 0);
    scan(0, 10, 0, 0);
    scan(0, 0, 1, 0);
    scan(4, 0, 0, 100);
    scan(4, 0, 0, 0);
    scan(4, 7, 0, 0);
    scan3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
